// File: rtl/bus_pkg.sv
// Shared types and constants for the system-bus arbiter.
// The optional watchdog is compiled in with BUS_WATCHDOG_EN.
package bus_pkg;

    localparam int DEFAULT_NR_MASTERS     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    localparam int D_CACHE = 0;
    localparam int I_CACHE = 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GRANT       = 3'd1,
        WAIT_BEGIN  = 3'd2,
        BUSY        = 3'd3,
        TIMEOUT_ERR = 3'd4,
        TIMEOUT_END = 3'd5
    } busState_e;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after lastGrant, wrapping
// modulo NR_MASTERS.
module rr_select #(
    parameter int NR_MASTERS = 4,
    parameter int IDX_W      = $clog2(NR_MASTERS)
) (
    input  logic [NR_MASTERS-1:0] requests,
    input  logic [IDX_W-1:0]      lastGrant,
    output logic [IDX_W-1:0]      index,
    output logic                  valid
);

    int cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = NR_MASTERS; off >= 1; off--) begin
            cand = (int'(lastGrant) + off) % NR_MASTERS;
            if (requests[IDX_W'(cand)]) begin
                index = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus with transaction tracking.
// Define BUS_WATCHDOG_EN to add the no-response watchdog (bus error + end).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NR_MASTERS     = DEFAULT_NR_MASTERS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_MASTERS-1:0] busRequests,
    output logic [NR_MASTERS-1:0] busGrants,
    input  logic                  beginTransactionIn,
    input  logic                  endTransactionIn,
    input  logic                  dataValidIn,
    input  logic                  busyIn,
    output logic                  busErrorOut,
    output logic                  endTransactionOut,
    output logic                  busIdle,
    output busState_e             debugState
);

    localparam int IDX_W = $clog2(NR_MASTERS);

    // Handshake: a master holds its busRequests bit as a level until it sees
    // its busGrants bit pulse for one cycle; it must then raise
    // beginTransactionIn in the very next cycle or the grant is forfeited.

    busState_e        state, nextState;
    logic [IDX_W-1:0] selIdx, lastGrant, pickIdx;
    logic             pickValid;
    logic             wdExpired;

    rr_select #(.NR_MASTERS(NR_MASTERS), .IDX_W(IDX_W)) u_rr_select (
        .requests (busRequests),
        .lastGrant(lastGrant),
        .index    (pickIdx),
        .valid    (pickValid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            selIdx    <= '0;
            lastGrant <= IDX_W'(NR_MASTERS - 1);
        end else begin
            state <= nextState;
            if (state == IDLE && pickValid) selIdx <= pickIdx;
            if (state == GRANT) lastGrant <= selIdx;
        end
    end

`ifdef BUS_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wdCount;

    // Cleared in WAIT_BEGIN so it reads zero on the first BUSY cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdCount <= '0;
        end else if (state == WAIT_BEGIN || dataValidIn || busyIn) begin
            wdCount <= '0;
        end else if (state == BUSY && wdCount != '1) begin
            wdCount <= wdCount + 1'b1;
        end
    end

    assign wdExpired = (wdCount == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unusedTimeout = TIMEOUT_CYCLES;
    logic unusedActivity;
    assign unusedActivity = dataValidIn | busyIn;
    assign wdExpired      = 1'b0;
`endif

    always_comb begin
        nextState         = state;
        busGrants         = '0;
        busErrorOut       = 1'b0;
        endTransactionOut = 1'b0;
        case (state)
            IDLE:       if (pickValid) nextState = GRANT;
            GRANT: begin
                busGrants = NR_MASTERS'(1) << selIdx;
                nextState = WAIT_BEGIN;
            end
            WAIT_BEGIN: nextState = beginTransactionIn ? BUSY : IDLE;
            BUSY: begin
                if (endTransactionIn)  nextState = IDLE;
                else if (wdExpired)    nextState = TIMEOUT_ERR;
            end
`ifdef BUS_WATCHDOG_EN
            TIMEOUT_ERR: begin
                busErrorOut = 1'b1;
                nextState   = TIMEOUT_END;
            end
            TIMEOUT_END: begin
                endTransactionOut = 1'b1;
                nextState         = IDLE;
            end
`endif
            default:    nextState = IDLE;
        endcase
    end

    assign busIdle    = (state == IDLE);
    assign debugState = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: grant scoreboard plus per-scenario tasks.
// Watchdog scenarios follow BUS_WATCHDOG_EN, matching the RTL build.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] busRequests;
    logic [N-1:0] busGrants;
    logic         beginTransactionIn, endTransactionIn, dataValidIn, busyIn;
    logic         busErrorOut, endTransactionOut, busIdle;
    busState_e    debugState;

    int checks = 0;
    int bad    = 0;
    int errPulses = 0;
    int endPulses = 0;
    logic [1:0] expQ[$];

    bus_arbiter #(.NR_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .busRequests       (busRequests),
        .busGrants         (busGrants),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn  (endTransactionIn),
        .dataValidIn       (dataValidIn),
        .busyIn            (busyIn),
        .busErrorOut       (busErrorOut),
        .endTransactionOut (endTransactionOut),
        .busIdle           (busIdle),
        .debugState        (debugState)
    );

    always #5 clock = ~clock;

    // Grant monitor: every grant pulse must match the next expected master.
    always @(negedge clock) begin
        logic [1:0]   e;
        logic [N-1:0] oh;
        if (!reset) begin
            if (busErrorOut) errPulses++;
            if (endTransactionOut) endPulses++;
            if (busGrants != '0) begin
                checks++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_grant got=%b expected=none", busGrants);
                end else begin
                    e  = expQ.pop_front();
                    oh = N'(1) << e;
                    if (busGrants !== oh) begin
                        bad++;
                        $display("FAIL sb_grant got=%b expected=%b", busGrants, oh);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        busRequests = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        dataValidIn = 1'b0;
        busyIn = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        expQ.delete();
    endtask

    task automatic waitGrant(input int idx);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (busGrants != '0) break;
        end
        checks++;
        if (busGrants !== oh) begin
            bad++;
            $display("FAIL grant_wait got=%b expected=%b", busGrants, oh);
        end
    endtask

    // Called in the GRANT cycle; ends back in IDLE.
    task automatic runTxn(input int endDelay);
        tick;
        beginTransactionIn = 1'b1;
        tick;
        beginTransactionIn = 1'b0;
        repeat (endDelay) tick;
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
    endtask

    task automatic enterBusy(input int idx);
        busRequests = N'(1) << idx;
        expQ.push_back(2'(idx));
        waitGrant(idx);
        busRequests = '0;
        tick;
        beginTransactionIn = 1'b1;
        tick;
        beginTransactionIn = 1'b0;
    endtask

    task automatic test_reset;
        doReset;
        reset = 1'b1;
        tick;
        checks++;
        if (busGrants !== '0 || busIdle !== 1'b1 || busErrorOut !== 1'b0 ||
            endTransactionOut !== 1'b0 || debugState !== IDLE) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d expected=0000/1/0/0/0",
                     busGrants, busIdle, busErrorOut, endTransactionOut, debugState);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        doReset;
        busRequests = 4'b0001;
        expQ.push_back(2'd0);
        tick;
        checks++;
        if (busGrants !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant_latency got=%b expected=0001", busGrants);
        end
        busRequests = '0;
        tick;
        beginTransactionIn = 1'b1;
        tick;
        beginTransactionIn = 1'b0;
        checks++;
        if (debugState !== BUSY || busIdle !== 1'b0) begin
            bad++;
            $display("FAIL single_busy got=%0d/%b expected=%0d/0", debugState, busIdle, BUSY);
        end
        tick;
        tick;
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        checks++;
        if (busIdle !== 1'b1) begin
            bad++;
            $display("FAIL single_idle got=%b expected=1", busIdle);
        end
    endtask

    task automatic test_round_robin;
        int order[6] = '{0, 1, 3, 0, 1, 3};
        doReset;
        busRequests = 4'b1011;
        foreach (order[i]) expQ.push_back(2'(order[i]));
        foreach (order[i]) begin
            waitGrant(order[i]);
            runTxn(1);
        end
        busRequests = '0;
    endtask

    task automatic test_withdrawal;
        int errBefore;
        int order[4] = '{3, 0, 1, 2};
        doReset;
        errBefore = errPulses;
        busRequests = 4'b0100;
        expQ.push_back(2'd2);
        waitGrant(2);
        busRequests = '0;
        tick;
        tick;
        checks++;
        if (busIdle !== 1'b1 || errPulses != errBefore) begin
            bad++;
            $display("FAIL withdraw_idle got=%b/%0d expected=1/%0d", busIdle, errPulses, errBefore);
        end
        busRequests = 4'b1111;
        foreach (order[i]) expQ.push_back(2'(order[i]));
        foreach (order[i]) begin
            waitGrant(order[i]);
            runTxn(1);
        end
        busRequests = '0;
    endtask

    task automatic test_watchdog;
        int n;
        int errBefore;
        doReset;
`ifdef BUS_WATCHDOG_EN
        enterBusy(1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (busErrorOut) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 8) begin
            bad++;
            $display("FAIL wd_error_delay got=%0d expected=8", n);
        end
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        checks++;
        if (endTransactionOut !== 1'b1 || busErrorOut !== 1'b0) begin
            bad++;
            $display("FAIL wd_end_pulse got=%b/%b expected=1/0", endTransactionOut, busErrorOut);
        end
        tick;
        checks++;
        if (busIdle !== 1'b1) begin
            bad++;
            $display("FAIL wd_idle got=%b expected=1", busIdle);
        end
        // End arriving in the same cycle as expiry wins.
        errBefore = errPulses;
        enterBusy(2);
        repeat (7) tick;
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        tick;
        checks++;
        if (busIdle !== 1'b1 || errPulses != errBefore) begin
            bad++;
            $display("FAIL wd_end_wins got=%b/%0d expected=1/%0d", busIdle, errPulses, errBefore);
        end
        // Periodic busy activity keeps reloading the counter.
        errBefore = errPulses;
        enterBusy(3);
        for (int k = 1; k <= 40; k++) begin
            tick;
            busyIn = (k % 6 == 0);
        end
        busyIn = 1'b0;
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        checks++;
        if (busIdle !== 1'b1 || errPulses != errBefore) begin
            bad++;
            $display("FAIL wd_reload got=%b/%0d expected=1/%0d", busIdle, errPulses, errBefore);
        end
`else
        errBefore = errPulses;
        n = endPulses;
        enterBusy(1);
        repeat (40) tick;
        checks++;
        if (debugState !== BUSY) begin
            bad++;
            $display("FAIL nowd_stays_busy got=%0d expected=%0d", debugState, BUSY);
        end
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        checks++;
        if (busIdle !== 1'b1 || errPulses != errBefore || endPulses != n) begin
            bad++;
            $display("FAIL nowd_no_pulses got=%b/%0d/%0d expected=1/%0d/%0d",
                     busIdle, errPulses, endPulses, errBefore, n);
        end
`endif
    endtask

    task automatic test_reset_mid_busy;
        int errBefore;
        int endBefore;
        doReset;
        enterBusy(2);
        errBefore = errPulses;
        endBefore = endPulses;
        busRequests = 4'b1111;
        reset = 1'b1;
        tick;
        checks++;
        if (busGrants !== '0 || busIdle !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state got=%b/%b expected=0000/1", busGrants, busIdle);
        end
        reset = 1'b0;
        expQ.push_back(2'd0);
        waitGrant(0);
        busRequests = '0;
        runTxn(1);
        checks++;
        if (errPulses != errBefore || endPulses != endBefore) begin
            bad++;
            $display("FAIL midreset_pulses got=%0d/%0d expected=%0d/%0d",
                     errPulses, endPulses, errBefore, endBefore);
        end
    endtask

    task automatic test_random;
        int modelLast;
        int expIdx;
        logic [N-1:0] mask;
        doReset;
        modelLast = N - 1;
        for (int t = 0; t < 10; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            expIdx = -1;
            for (int off = 1; off <= N; off++) begin
                if (expIdx < 0 && mask[(modelLast + off) % N]) expIdx = (modelLast + off) % N;
            end
            busRequests = mask;
            expQ.push_back(2'(expIdx));
            waitGrant(expIdx);
            modelLast = expIdx;
            busRequests = '0;
            runTxn($urandom_range(0, 3));
        end
    endtask

    initial begin
        doReset;
        test_reset;
        test_single;
        test_round_robin;
        test_withdrawal;
        test_watchdog;
        test_reset_mid_busy;
        test_random;
        repeat (3) tick;
        checks++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d expected=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
